dmem_rr_arbiter: RTL and testbench
==================================

Name: dmem_rr_arbiter

Overview:
- Two-requester round-robin arbiter that shares the single-port 4096x32 on-chip data memory (byte-enabled, 1-cycle read latency) between two Avalon-MM style masters.
- Typical pairing: CPU data master plus DFT/DMA master.
- Sits between the masters and the memory slave. Issues at most one access per cycle, backpressures the loser with waitrequest, and routes read data back with a per-master readdatavalid.

Parameters:
- ADDR_W, 12, word address width (4096 words).
- DATA_W, 32, data width; byteenable width is DATA_W/8.
- RD_LAT, 1, memory read latency in cycles; legal values 1 or 2 (2 = memory output registered).

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- m0_address  in  ADDR_W  master 0 word address
- m0_byteenable  in  DATA_W/8  master 0 byte lanes
- m0_read  in  1  master 0 read request
- m0_write  in  1  master 0 write request
- m0_writedata  in  DATA_W  master 0 write data
- m0_waitrequest  out  1  master 0 stall; request not accepted this cycle
- m0_readdata  out  DATA_W  master 0 read data
- m0_readdatavalid  out  1  master 0 read data valid
- m1_*  same set as m0_*, for master 1
- ram_address  out  ADDR_W  to memory address
- ram_byteenable  out  DATA_W/8  to memory byteenable
- ram_chipselect  out  1  to memory chipselect
- ram_write  out  1  to memory write
- ram_writedata  out  DATA_W  to memory writedata
- ram_clken  out  1  to memory clken; tied to 1
- ram_readdata  in  DATA_W  from memory readdata

Behaviour:
- Request: req_i = mi_read | mi_write. A master holds its request and all qualifiers stable while mi_waitrequest=1.
- Grant (combinational, same cycle):
  - Only one master requesting: that master wins.
  - Both requesting: the master not equal to last_grant wins.
  - No request: no grant, ram_chipselect=0, ram_write=0.
- mi_waitrequest = req_i & ~grant_i. A non-requesting master sees waitrequest=0.
- Transfer accepted when req_i & grant_i. In that cycle:
  - ram_* carry master i's address, byteenable and writedata.
  - ram_chipselect=1; ram_write=mi_write.
- last_grant (1-bit register) updates to i on each accepted transfer only; it holds when idle. Reset value 0, so master 1 wins the first contention.
- Read and write asserted together by one master: treated as a write; no readdatavalid is generated.
- Read return pipeline:
  - RD_LAT-deep shift register of {valid, owner}, loaded on each accepted read.
  - mi_readdatavalid=1 exactly RD_LAT cycles after acceptance, for the owning master only.
  - mi_readdata = ram_readdata for both masters (shared bus); data is qualified only by readdatavalid.
- Back-to-back: one accepted access per cycle sustained. Pipelined reads from alternating masters return in issue order, one per cycle.
- Write then read of the same address on consecutive cycles returns the new data (memory is single port; ordering is serialised by the arbiter).
- byteenable=0 on a write is forwarded as-is: accepted, no memory change.
- Reset (asynchronous):
  - Clears last_grant and the return pipeline, so reads in flight produce no readdatavalid.
  - Outputs during reset: all waitrequest=1, all readdatavalid=0, ram_chipselect=0, ram_write=0.
  - Normal operation resumes on the first clk edge after reset deasserts.
- Starvation bound: a requesting master is accepted within 2 cycles of raising its request.

Optional Feature:
- Macro: DMEM_ARB_STATS_EN.
- When defined, adds outputs m0_grant_cnt[15:0], m1_grant_cnt[15:0] and m_conflict_cnt[15:0], plus input stats_clr.
  - Grant counters increment on each accepted transfer of their master.
  - m_conflict_cnt increments on each cycle where both masters request.
  - All counters saturate at 16'hFFFF.
  - Counters clear on reset or on stats_clr=1. stats_clr has priority over an increment in the same cycle.
- When undefined, these ports and registers do not exist and arbitration is unchanged.

Test Plan:
- Solo access: m0 writes 0xDEADBEEF to addr 0x010 (be=4'hF), then reads 0x010 -> no waitrequest on either cycle; m0_readdatavalid one cycle after the read with readdata 0xDEADBEEF; m1_readdatavalid stays 0.
- Contention: after reset, m0 and m1 both read addr 0x020 for 2 cycles -> m1 accepted cycle 0 (m0_waitrequest=1), m0 accepted cycle 1; valids arrive m1 then m0 in consecutive cycles.
- Fairness: both masters request continuously for 8 cycles -> grants alternate 1,0,1,0,...; 4 accepted transfers each.
- Byte lanes: write 0x11223344 to 0x7FF, then write 0xAAAAAAAA with be=4'b0100, then read 0x7FF -> 0x11AA3344.
- Reset mid-operation: assert reset in the cycle after an accepted m1 read -> no m1_readdatavalid; after release, last_grant=0 and a contested access is granted to m1.
- Stats build with DMEM_ARB_STATS_EN: 5 contested cycles -> m_conflict_cnt=5; pulse stats_clr -> all counters 0 on the next cycle.

Source files
------------

// File: rtl/dmem_rr_arbiter_if.sv
// Avalon-MM style master bundle for one requester of dmem_rr_arbiter.
// The master modport drives the request side; the slave modport is the arbiter side.
interface dmem_rr_arbiter_if #(
    parameter int unsigned ADDR_W = 12,
    parameter int unsigned DATA_W = 32
);
    logic [ADDR_W-1:0]   address;
    logic [DATA_W/8-1:0] byteenable;
    logic                read;
    logic                write;
    logic [DATA_W-1:0]   writedata;
    logic                waitrequest;
    logic [DATA_W-1:0]   readdata;
    logic                readdatavalid;

    modport master (
        output address, byteenable, read, write, writedata,
        input  waitrequest, readdata, readdatavalid
    );

    modport slave (
        input  address, byteenable, read, write, writedata,
        output waitrequest, readdata, readdatavalid
    );
endinterface

// File: rtl/dmem_rr_arbiter.sv
// Two-master round-robin arbiter in front of the single-port data memory.
// Optional grant/conflict statistics counters are enabled by defining DMEM_ARB_STATS_EN.
module dmem_rr_arbiter #(
    parameter int unsigned ADDR_W = 12,
    parameter int unsigned DATA_W = 32,
    parameter int unsigned RD_LAT = 1
) (
    input  logic                clk,
    input  logic                reset,
    dmem_rr_arbiter_if.slave    m0,
    dmem_rr_arbiter_if.slave    m1,
    output logic [ADDR_W-1:0]   ram_address,
    output logic [DATA_W/8-1:0] ram_byteenable,
    output logic                ram_chipselect,
    output logic                ram_write,
    output logic [DATA_W-1:0]   ram_writedata,
    output logic                ram_clken,
    input  logic [DATA_W-1:0]   ram_readdata
`ifdef DMEM_ARB_STATS_EN
    ,
    input  logic                stats_clr,
    output logic [15:0]         m0_grant_cnt,
    output logic [15:0]         m1_grant_cnt,
    output logic [15:0]         m_conflict_cnt
`endif
);

    logic              req0;
    logic              req1;
    logic              grant0;
    logic              grant1;
    logic              last_grant;
    logic              rd_accept;
    logic [RD_LAT-1:0] pipe_valid;
    logic [RD_LAT-1:0] pipe_owner;

    assign req0 = m0.read | m0.write;
    assign req1 = m1.read | m1.write;

    // On contention the master that did not win last time gets the slot.
    always_comb begin
        grant1 = ~reset & req1 & (~req0 | ~last_grant);
        grant0 = ~reset & req0 & ~grant1;
    end

    always_comb begin
        ram_clken      = 1'b1;
        ram_chipselect = grant0 | grant1;
        ram_address    = grant1 ? m1.address    : m0.address;
        ram_byteenable = grant1 ? m1.byteenable : m0.byteenable;
        ram_writedata  = grant1 ? m1.writedata  : m0.writedata;
        ram_write      = (grant1 & m1.write) | (grant0 & m0.write);
        rd_accept      = ram_chipselect & ~ram_write;
    end

    always_comb begin
        m0.waitrequest   = reset | (req0 & ~grant0);
        m1.waitrequest   = reset | (req1 & ~grant1);
        m0.readdata      = ram_readdata;
        m1.readdata      = ram_readdata;
        m0.readdatavalid = pipe_valid[RD_LAT-1] & ~pipe_owner[RD_LAT-1];
        m1.readdatavalid = pipe_valid[RD_LAT-1] &  pipe_owner[RD_LAT-1];
    end

    // Shift in at bit 0; the cast drops the oldest stage, which also covers RD_LAT=1.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            last_grant <= 1'b0;
            pipe_valid <= '0;
            pipe_owner <= '0;
        end else begin
            if (grant0 | grant1) begin
                last_grant <= grant1;
            end
            pipe_valid <= RD_LAT'({pipe_valid, rd_accept});
            pipe_owner <= RD_LAT'({pipe_owner, grant1});
        end
    end

`ifdef DMEM_ARB_STATS_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            m0_grant_cnt   <= '0;
            m1_grant_cnt   <= '0;
            m_conflict_cnt <= '0;
        end else if (stats_clr) begin
            m0_grant_cnt   <= '0;
            m1_grant_cnt   <= '0;
            m_conflict_cnt <= '0;
        end else begin
            if (grant0 && m0_grant_cnt != '1) begin
                m0_grant_cnt <= m0_grant_cnt + 16'd1;
            end
            if (grant1 && m1_grant_cnt != '1) begin
                m1_grant_cnt <= m1_grant_cnt + 16'd1;
            end
            if (req0 && req1 && m_conflict_cnt != '1) begin
                m_conflict_cnt <= m_conflict_cnt + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_dmem_rr_arbiter.sv
// Randomized and directed bench for dmem_rr_arbiter against a behavioural model.
// Define DMEM_ARB_STATS_EN to also exercise the statistics counters.
module tb_dmem_rr_arbiter;

    localparam int RD_LAT = 1;

    logic        clk = 1'b0;
    logic        reset;
    logic [11:0] ram_address;
    logic [3:0]  ram_byteenable;
    logic        ram_chipselect;
    logic        ram_write;
    logic [31:0] ram_writedata;
    logic        ram_clken;
    logic [31:0] ram_readdata;
`ifdef DMEM_ARB_STATS_EN
    logic        stats_clr;
    logic [15:0] m0_grant_cnt;
    logic [15:0] m1_grant_cnt;
    logic [15:0] m_conflict_cnt;
`endif

    dmem_rr_arbiter_if #(.ADDR_W(12), .DATA_W(32)) m0_bus ();
    dmem_rr_arbiter_if #(.ADDR_W(12), .DATA_W(32)) m1_bus ();

    dmem_rr_arbiter #(.ADDR_W(12), .DATA_W(32), .RD_LAT(RD_LAT)) dut (
        .clk            (clk),
        .reset          (reset),
        .m0             (m0_bus),
        .m1             (m1_bus),
        .ram_address    (ram_address),
        .ram_byteenable (ram_byteenable),
        .ram_chipselect (ram_chipselect),
        .ram_write      (ram_write),
        .ram_writedata  (ram_writedata),
        .ram_clken      (ram_clken),
        .ram_readdata   (ram_readdata)
`ifdef DMEM_ARB_STATS_EN
        ,
        .stats_clr      (stats_clr),
        .m0_grant_cnt   (m0_grant_cnt),
        .m1_grant_cnt   (m1_grant_cnt),
        .m_conflict_cnt (m_conflict_cnt)
`endif
    );

    always #5 clk = ~clk;

    // Memory behind the arbiter
    logic [31:0] ram_mem [4096];
    logic [31:0] ram_q   [RD_LAT];
    assign ram_readdata = ram_q[RD_LAT-1];

    always @(posedge clk) begin
        if (ram_chipselect && ram_clken) begin
            if (ram_write) begin
                for (int b = 0; b < 4; b++)
                    if (ram_byteenable[b]) ram_mem[ram_address][8*b +: 8] <= ram_writedata[8*b +: 8];
            end else begin
                ram_q[0] <= ram_mem[ram_address];
            end
        end
        for (int k = 1; k < RD_LAT; k++) ram_q[k] <= ram_q[k-1];
    end

    int compared   = 0;
    int mismatched = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Behavioural model state
    typedef struct {
        int          due;
        int          owner;
        logic [31:0] data;
    } ret_t;

    logic [31:0] ref_mem [4096];
    ret_t        ret_q[$];
    int          model_last;
    int          cyc;
    bit          model_wait [2];
    int          gq[$];
    int          rq[$];
    int          rdv_cnt [2];
    logic [31:0] last_rd [2];
    int          st_g [2];
    int          st_c;

    int          w;
    int          e_owner;
    logic [31:0] e_data;
    logic        r0, r1, sel_wr, sel_rd;
    logic [11:0] sel_a;
    logic [3:0]  sel_be;
    logic [31:0] sel_d;

    always @(negedge clk) begin
        if (reset) begin
            chk("rst_wait0", m0_bus.waitrequest, 1);
            chk("rst_wait1", m1_bus.waitrequest, 1);
            chk("rst_rdv0", m0_bus.readdatavalid, 0);
            chk("rst_rdv1", m1_bus.readdatavalid, 0);
            chk("rst_cs", ram_chipselect, 0);
            chk("rst_wr", ram_write, 0);
            ret_q.delete();
            model_last = 0;
            model_wait[0] = 0;
            model_wait[1] = 0;
            st_g[0] = 0; st_g[1] = 0; st_c = 0;
        end else begin
            r0 = m0_bus.read | m0_bus.write;
            r1 = m1_bus.read | m1_bus.write;
            if (r0 && r1)  w = 1 - model_last;
            else if (r0)   w = 0;
            else if (r1)   w = 1;
            else           w = -1;

            chk("wait0", m0_bus.waitrequest, r0 && w != 0);
            chk("wait1", m1_bus.waitrequest, r1 && w != 1);
            chk("cs", ram_chipselect, w >= 0);
            chk("clken", ram_clken, 1);

            if (w >= 0) begin
                sel_wr = (w == 1) ? m1_bus.write      : m0_bus.write;
                sel_rd = (w == 1) ? m1_bus.read       : m0_bus.read;
                sel_a  = (w == 1) ? m1_bus.address    : m0_bus.address;
                sel_be = (w == 1) ? m1_bus.byteenable : m0_bus.byteenable;
                sel_d  = (w == 1) ? m1_bus.writedata  : m0_bus.writedata;
                chk("ram_wr", ram_write, sel_wr);
                chk("ram_addr", ram_address, sel_a);
                chk("ram_be", ram_byteenable, sel_be);
                chk("ram_wdata", ram_writedata, sel_d);
            end else begin
                chk("ram_wr_idle", ram_write, 0);
            end

            e_owner = -1;
            e_data  = '0;
            if (ret_q.size() > 0 && ret_q[0].due == cyc) begin
                e_owner = ret_q[0].owner;
                e_data  = ret_q[0].data;
                void'(ret_q.pop_front());
            end
            chk("rdv0", m0_bus.readdatavalid, e_owner == 0);
            chk("rdv1", m1_bus.readdatavalid, e_owner == 1);
            if (e_owner == 0) chk("rdata0", m0_bus.readdata, e_data);
            if (e_owner == 1) chk("rdata1", m1_bus.readdata, e_data);

`ifdef DMEM_ARB_STATS_EN
            chk("g0_cnt", m0_grant_cnt, st_g[0]);
            chk("g1_cnt", m1_grant_cnt, st_g[1]);
            chk("c_cnt", m_conflict_cnt, st_c);
            if (stats_clr) begin
                st_g[0] = 0; st_g[1] = 0; st_c = 0;
            end else begin
                if (w >= 0 && st_g[w] < 65535) st_g[w]++;
                if (r0 && r1 && st_c < 65535) st_c++;
            end
`endif

            // Observed DUT behaviour, used by the directed literal checks
            if (r0 && !m0_bus.waitrequest) gq.push_back(0);
            if (r1 && !m1_bus.waitrequest) gq.push_back(1);
            if (m0_bus.readdatavalid) begin rdv_cnt[0]++; last_rd[0] = m0_bus.readdata; rq.push_back(0); end
            if (m1_bus.readdatavalid) begin rdv_cnt[1]++; last_rd[1] = m1_bus.readdata; rq.push_back(1); end

            if (w >= 0) begin
                model_last = w;
                if (sel_wr) begin
                    for (int b = 0; b < 4; b++)
                        if (sel_be[b]) ref_mem[sel_a][8*b +: 8] = sel_d[8*b +: 8];
                end else if (sel_rd) begin
                    ret_q.push_back('{due: cyc + RD_LAT, owner: w, data: ref_mem[sel_a]});
                end
            end
            model_wait[0] = r0 && w != 0;
            model_wait[1] = r1 && w != 1;
        end
        cyc++;
    end

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input int m, input logic rd, input logic wr, input logic [11:0] a,
                         input logic [3:0] be, input logic [31:0] d);
        if (m == 0) begin
            m0_bus.read = rd; m0_bus.write = wr; m0_bus.address = a;
            m0_bus.byteenable = be; m0_bus.writedata = d;
        end else begin
            m1_bus.read = rd; m1_bus.write = wr; m1_bus.address = a;
            m1_bus.byteenable = be; m1_bus.writedata = d;
        end
    endtask

    task automatic idle_all();
        drive(0, 0, 0, '0, '0, '0);
        drive(1, 0, 0, '0, '0, '0);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        cycle();
        cycle();
        reset = 1'b0;
    endtask

    int saved;
    int sel;

    initial begin
        for (int i = 0; i < 4096; i++) begin
            ram_mem[i] = '0;
            ref_mem[i] = '0;
        end
        ram_q[0] = '0;
        cyc = 0; model_last = 0;
        rdv_cnt[0] = 0; rdv_cnt[1] = 0;
        st_g[0] = 0; st_g[1] = 0; st_c = 0;
`ifdef DMEM_ARB_STATS_EN
        stats_clr = 1'b0;
`endif
        idle_all();
        reset = 1'b1;
        #1;
        do_reset();

        // Solo write then read by m0
        saved = rdv_cnt[1];
        drive(0, 0, 1, 12'h010, 4'hF, 32'hDEADBEEF); cycle();
        drive(0, 1, 0, 12'h010, 4'hF, 32'h0);        cycle();
        idle_all(); cycle(); cycle();
        chk("solo_rdata", last_rd[0], 32'hDEADBEEF);
        chk("solo_m1_quiet", rdv_cnt[1], saved);

        // Contention straight after reset: m1 first
        do_reset();
        gq.delete(); rq.delete();
        drive(0, 1, 0, 12'h020, 4'hF, 0);
        drive(1, 1, 0, 12'h020, 4'hF, 0);
        cycle();
        drive(1, 0, 0, 0, 0, 0);
        cycle();
        idle_all(); cycle(); cycle();
        chk("cont_ngrant", gq.size(), 2);
        if (gq.size() == 2) begin
            chk("cont_g0", gq[0], 1);
            chk("cont_g1", gq[1], 0);
        end
        chk("cont_nrdv", rq.size(), 2);
        if (rq.size() == 2) begin
            chk("cont_r0", rq[0], 1);
            chk("cont_r1", rq[1], 0);
        end

        // Fairness: 8 cycles of continuous contention
        gq.delete();
        drive(0, 1, 0, 12'h005, 4'hF, 0);
        drive(1, 1, 0, 12'h006, 4'hF, 0);
        repeat (8) cycle();
        idle_all(); cycle(); cycle();
        chk("fair_n", gq.size(), 8);
        for (int i = 0; i < 8 && i < gq.size(); i++)
            chk("fair_seq", gq[i], (i % 2 == 0) ? 1 : 0);

        // Byte-lane merge
        drive(0, 0, 1, 12'h7FF, 4'hF, 32'h11223344);    cycle();
        drive(0, 0, 1, 12'h7FF, 4'b0100, 32'hAAAAAAAA); cycle();
        drive(0, 0, 1, 12'h7FF, 4'h0, 32'hFFFFFFFF);    cycle();
        drive(0, 1, 0, 12'h7FF, 4'hF, 0);               cycle();
        idle_all(); cycle(); cycle();
        chk("be_rdata", last_rd[0], 32'h11AA3344);

        // Reset while an m1 read is in flight
        saved = rdv_cnt[1];
        drive(1, 1, 0, 12'h030, 4'hF, 0); cycle();
        idle_all();
        reset = 1'b1; cycle();
        reset = 1'b0; cycle(); cycle();
        chk("rst_flush", rdv_cnt[1], saved);
        gq.delete();
        drive(0, 1, 0, 12'h031, 4'hF, 0);
        drive(1, 1, 0, 12'h032, 4'hF, 0);
        cycle();
        idle_all(); cycle(); cycle();
        chk("rst_first_grant", (gq.size() > 0) ? gq[0] : -1, 1);

`ifdef DMEM_ARB_STATS_EN
        do_reset();
        drive(0, 1, 0, 12'h001, 4'hF, 0);
        drive(1, 1, 0, 12'h002, 4'hF, 0);
        repeat (5) cycle();
        idle_all();
        chk("st_conflict", m_conflict_cnt, 5);
        chk("st_g0", m0_grant_cnt, 2);
        chk("st_g1", m1_grant_cnt, 3);
        stats_clr = 1'b1; cycle();
        stats_clr = 1'b0;
        chk("st_clr_c", m_conflict_cnt, 0);
        chk("st_clr_g0", m0_grant_cnt, 0);
        chk("st_clr_g1", m1_grant_cnt, 0);
`endif

        // Randomized traffic with hold-while-waiting
        for (int n = 0; n < 3000; n++) begin
            for (int m = 0; m < 2; m++) begin
                if (!model_wait[m]) begin
                    sel = $urandom_range(0, 9);
                    drive(m, (sel >= 3 && sel <= 5) || sel == 9, (sel >= 6),
                          12'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), $urandom);
                end
            end
`ifdef DMEM_ARB_STATS_EN
            stats_clr = ($urandom_range(0, 99) == 0);
`endif
            cycle();
        end
        idle_all();
`ifdef DMEM_ARB_STATS_EN
        stats_clr = 1'b0;
`endif
        cycle(); cycle(); cycle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
